fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the 16-bit TSC pipeline; sits directly upstream of the ID stage.
- Consumes the hazard unit's pc_write / ir_write / flush_if.
- Owns the PC, the instruction-memory read handshake, a direct-mapped BTB with 2-bit counters, and the IF/ID instruction register.
- Produces the IR, PC and prediction bits that ID compares against to form jump_miss / branch_miss.

Parameters:
- WORD, 16, datapath/address width.
- RESET_PC, 16'h0000, PC value after reset.
- BTB_IDX, 2, BTB index bits (2^BTB_IDX entries); tag = pc[WORD-1:BTB_IDX].
- NOP_INST, 16'hF01C, encoding loaded into IR on flush/bubble; control decodes it as no-op.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- pc_write  in  1  hazard unit: PC may advance.
- ir_write  in  1  hazard unit: IR may load.
- flush_if  in  1  hazard unit: replace the instruction entering ID with NOP_INST.
- redirect_valid  in  1  ID/EX resolved a misprediction or jump.
- redirect_pc  in  WORD  correct next PC.
- upd_valid  in  1  resolved branch/jump: train BTB.
- upd_pc  in  WORD  PC of the resolved instruction.
- upd_target  in  WORD  its taken target.
- upd_taken  in  1  actual outcome.
- i_readM  out  1  instruction memory read request.
- i_address  out  WORD  read address.
- i_data  in  WORD  read data.
- i_inputReady  in  1  data valid, one-cycle pulse.
- ir_id  out  WORD  IF/ID instruction.
- pc_id  out  WORD  PC of ir_id.
- ir_valid_id  out  1  ir_id is a real instruction; gates incr_num_inst.
- pred_taken_id  out  1  prediction made for ir_id.
- pred_target_id  out  WORD  predicted next PC for ir_id.

Behaviour:
- Reset (async, reset_n=0) sets:
  - pc=RESET_PC, state=FETCH, kill=0.
  - ir_id=NOP_INST, pc_id=0, ir_valid_id=0, pred_taken_id=0, pred_target_id=0.
  - All BTB valid=0, all counters=2'b01.
  - i_readM=0 while in reset.
- Prediction (combinational on pc): hit = valid[idx] && tag match. pred_taken = hit && ctr[idx][1]. next_pc = pred_taken ? target[idx] : pc+1 (mod 2^WORD, wrap 16'hFFFF->0).
- State FETCH:
  - i_readM=1, i_address=pc, held stable until i_inputReady.
  - No i_inputReady: PC holds. If ir_write, IR<=NOP_INST and ir_valid_id<=0 (bubble).
  - i_inputReady with kill=1: data discarded, kill<=0, stay FETCH; PC is already the redirect value.
  - i_inputReady with ir_write=1 and flush_if=0: IR<=i_data, pc_id<=pc, ir_valid_id<=1, pred_* latched. If pc_write, pc<=next_pc.
  - i_inputReady with ir_write=0: buf<=i_data and the prediction are saved, go HOLD.
- State HOLD:
  - i_readM=0.
  - When ir_write=1: IR<=buf (with saved pc/pred), pc<=saved next_pc if pc_write, go FETCH.
- Redirect (redirect_valid=1) has priority over every rule above except reset:
  - pc<=redirect_pc.
  - Any HOLD buffer is dropped; go FETCH.
  - If FETCH has an outstanding request without i_inputReady this cycle, kill<=1, so the address stays on the old pc until ready and the data is then discarded.
  - Exception to address stability: the request address moves to the new pc only on the cycle after ready.
- flush_if=1: on that edge IR<=NOP_INST and ir_valid_id<=0 regardless of fetched data. The fetched word is discarded, not buffered. PC<=redirect_pc if redirect_valid, else next_pc.
- Stall: pc_write=ir_write=0 freezes pc, IR and all *_id outputs.
- BTB update (same edge, independent of stalls):
  - On upd_valid with a tag hit: counter saturating ++ if taken, -- if not (bounded 00..11). Target<=upd_target if taken.
  - On a miss with upd_taken: install valid=1, tag, target, ctr=2'b10.
  - On a miss with not taken: no change.
  - Update and lookup on the same index in the same cycle: the lookup sees the old contents.
- ir_valid_id never 1 for a discarded or killed word.

Test Plan:
- Reset release, memory returns i_inputReady every cycle with data=addr+16'h1000 -> ir_id sequence 16'h1000,16'h1001,16'h1002; pc_id 0,1,2; ir_valid_id=1 from the second edge.
- Memory latency 3 cycles, ir_write=1 -> i_address held at 0x0005 for 3 cycles; ir_id=NOP_INST and ir_valid_id=0 on the two waiting edges.
- Data arrives while ir_write=0 for 2 cycles -> state HOLD, i_readM=0; ir_id loads buffered word on the first ir_write=1 edge; no re-fetch of the same pc.
- redirect_valid with redirect_pc=0x0040 mid-request (ready arrives 2 cycles later) -> returned word discarded, ir_valid_id stays 0, next request address 0x0040.
- upd_valid pc=0x0008 target=0x0020 taken twice, then fetch at 0x0008 -> pred_taken_id=1, pred_target_id=0x0020, next i_address=0x0020. Then 2 not-taken updates -> ctr=01, fetch predicts 0x0009.
- flush_if with redirect_pc=0x0010 coincident with i_inputReady -> ir_id=NOP_INST, ir_valid_id=0, next i_address=0x0010; async reset asserted mid-HOLD -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port of the TSC fetch stage.
// The fetch unit drives the request; the memory returns data with a ready pulse.
interface fetch_unit_if #(
  parameter int WORD = 16
);
  logic            i_readM;
  logic [WORD-1:0] i_address;
  logic [WORD-1:0] i_data;
  logic            i_inputReady;

  modport master (
    output i_readM,
    output i_address,
    input  i_data,
    input  i_inputReady
  );

  modport slave (
    input  i_readM,
    input  i_address,
    output i_data,
    output i_inputReady
  );
endinterface

// File: rtl/fetch_unit.sv
// IF stage of the 16-bit TSC pipeline: PC, imem handshake,
// direct-mapped BTB with 2-bit counters and the IF/ID register.
module fetch_unit #(
  parameter int              WORD     = 16,
  parameter logic [WORD-1:0] RESET_PC = '0,
  parameter int              BTB_IDX  = 2,
  parameter logic [WORD-1:0] NOP_INST = 16'hF01C
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            pc_write,
  input  logic            ir_write,
  input  logic            flush_if,
  input  logic            redirect_valid,
  input  logic [WORD-1:0] redirect_pc,
  input  logic            upd_valid,
  input  logic [WORD-1:0] upd_pc,
  input  logic [WORD-1:0] upd_target,
  input  logic            upd_taken,
  fetch_unit_if.master    imem,
  output logic [WORD-1:0] ir_id,
  output logic [WORD-1:0] pc_id,
  output logic            ir_valid_id,
  output logic            pred_taken_id,
  output logic [WORD-1:0] pred_target_id
);

  localparam int N    = 1 << BTB_IDX;
  localparam int TAGW = WORD - BTB_IDX;

  typedef logic [WORD-1:0]    word_t;
  typedef logic [TAGW-1:0]    tag_t;
  typedef logic [BTB_IDX-1:0] idx_t;

  typedef enum logic {
    S_FETCH,
    S_HOLD
  } state_t;

  typedef struct packed {
    word_t ir;
    word_t pc;
    logic  valid;
    logic  taken;
    word_t tgt;
  } if_id_t;

  typedef struct packed {
    word_t ir;
    word_t pc;
    logic  taken;
    word_t tgt;
  } hold_t;

  state_t state;
  if_id_t q;
  hold_t  hbuf;
  word_t  pc;
  word_t  pc_nxt;
  word_t  addr;
  logic   kill;
  logic   kill_nxt;
  logic   req;
  logic   rdy;

  logic [N-1:0] btb_valid;
  tag_t         btb_tag [N];
  word_t        btb_tgt [N];
  logic [1:0]   btb_ctr [N];

  idx_t  idx;
  idx_t  uidx;
  logic  hit;
  logic  uhit;
  logic  pred_taken;
  word_t next_pc;

  assign rdy = imem.i_inputReady;

  assign idx        = pc[BTB_IDX-1:0];
  assign hit        = btb_valid[idx] &&
                      btb_tag[idx] == pc[WORD-1:BTB_IDX];
  assign pred_taken = hit && btb_ctr[idx][1];
  assign next_pc    = pred_taken ? btb_tgt[idx]
                                 : pc + word_t'(1);

  assign uidx = upd_pc[BTB_IDX-1:0];
  assign uhit = btb_valid[uidx] &&
                btb_tag[uidx] == upd_pc[WORD-1:BTB_IDX];

  assign imem.i_readM   = req;
  assign imem.i_address = addr;

  assign ir_id          = q.ir;
  assign pc_id          = q.pc;
  assign ir_valid_id    = q.valid;
  assign pred_taken_id  = q.taken;
  assign pred_target_id = q.tgt;

  always_comb begin
    pc_nxt   = pc;
    kill_nxt = kill;
    if (redirect_valid) begin
      pc_nxt   = redirect_pc;
      kill_nxt = req && !rdy;
    end else if (state == S_FETCH && rdy) begin
      if (kill)
        kill_nxt = 1'b0;
      else if (flush_if || (ir_write && pc_write))
        pc_nxt = next_pc;
    end else if (state == S_HOLD) begin
      if (flush_if || (ir_write && pc_write))
        pc_nxt = hbuf.tgt;
    end
  end

  // A killed request keeps its old address until the stale word returns.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc   <= RESET_PC;
      addr <= RESET_PC;
      kill <= 1'b0;
    end else begin
      pc   <= pc_nxt;
      kill <= kill_nxt;
      if (!kill_nxt)
        addr <= pc_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_FETCH;
      req     <= 1'b0;
      q       <= '{ir: NOP_INST, default: '0};
      hbuf    <= '0;
    end else if (redirect_valid) begin
      state <= S_FETCH;
      req   <= 1'b1;
      if (flush_if || ir_write) begin
        q.ir    <= NOP_INST;
        q.valid <= 1'b0;
      end
    end else begin
      unique case (state)
        S_FETCH: begin
          req <= 1'b1;
          if (rdy && !kill && !flush_if && !ir_write) begin
            hbuf  <= '{ir: imem.i_data, pc: pc,
                       taken: pred_taken, tgt: next_pc};
            state <= S_HOLD;
            req   <= 1'b0;
          end else if (rdy && !kill && !flush_if) begin
            q <= '{ir: imem.i_data, pc: pc, valid: 1'b1,
                   taken: pred_taken, tgt: next_pc};
          end else if (flush_if || ir_write) begin
            q.ir    <= NOP_INST;
            q.valid <= 1'b0;
          end
        end
        S_HOLD: begin
          req <= 1'b0;
          if (flush_if) begin
            q.ir    <= NOP_INST;
            q.valid <= 1'b0;
            state   <= S_FETCH;
            req     <= 1'b1;
          end else if (ir_write) begin
            q <= '{ir: hbuf.ir, pc: hbuf.pc, valid: 1'b1,
                   taken: hbuf.taken, tgt: hbuf.tgt};
            state <= S_FETCH;
            req   <= 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btb_valid <= '0;
      for (int i = 0; i < N; i++) begin
        btb_tag[i] <= '0;
        btb_tgt[i] <= '0;
        btb_ctr[i] <= 2'b01;
      end
    end else if (upd_valid) begin
      if (uhit) begin
        if (upd_taken) begin
          btb_tgt[uidx] <= upd_target;
          if (btb_ctr[uidx] != 2'b11)
            btb_ctr[uidx] <= btb_ctr[uidx] + 2'b01;
        end else if (btb_ctr[uidx] != 2'b00) begin
          btb_ctr[uidx] <= btb_ctr[uidx] - 2'b01;
        end
      end else if (upd_taken) begin
        btb_valid[uidx] <= 1'b1;
        btb_tag[uidx]   <= upd_pc[WORD-1:BTB_IDX];
        btb_tgt[uidx]   <= upd_target;
        btb_ctr[uidx]   <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable
// instruction memory returning addr + 16'h1000.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pc_write;
  logic        ir_write;
  logic        flush_if;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        upd_valid;
  logic [15:0] upd_pc;
  logic [15:0] upd_target;
  logic        upd_taken;
  logic [15:0] ir_id;
  logic [15:0] pc_id;
  logic        ir_valid_id;
  logic        pred_taken_id;
  logic [15:0] pred_target_id;

  int checks = 0;
  int errors = 0;
  int lat    = 1;
  int cnt    = 0;

  fetch_unit_if #(.WORD(16)) imem ();

  fetch_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pc_write       (pc_write),
    .ir_write       (ir_write),
    .flush_if       (flush_if),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_target     (upd_target),
    .upd_taken      (upd_taken),
    .imem           (imem.master),
    .ir_id          (ir_id),
    .pc_id          (pc_id),
    .ir_valid_id    (ir_valid_id),
    .pred_taken_id  (pred_taken_id),
    .pred_target_id (pred_target_id)
  );

  always #5 clk = ~clk;

  initial begin
    imem.i_inputReady = 1'b0;
    imem.i_data       = '0;
  end

  always @(negedge clk) begin
    if (imem.i_readM) begin
      cnt = cnt + 1;
      imem.i_inputReady = (cnt >= lat);
      imem.i_data       = imem.i_address + 16'h1000;
    end else begin
      cnt = 0;
      imem.i_inputReady = 1'b0;
    end
  end

  always @(posedge clk)
    if (imem.i_inputReady) cnt = 0;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n        = 1'b0;
    pc_write       = 1'b1;
    ir_write       = 1'b1;
    flush_if       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    upd_valid      = 1'b0;
    upd_pc         = '0;
    upd_target     = '0;
    upd_taken      = 1'b0;
    tick();
    tick();
    chk("rst_ir",    ir_id, 16'hF01C);
    chk("rst_pc",    pc_id, 16'h0000);
    chk("rst_val",   16'(ir_valid_id), 16'h0);
    chk("rst_pt",    16'(pred_taken_id), 16'h0);
    chk("rst_ptg",   pred_target_id, 16'h0000);
    chk("rst_rd",    16'(imem.i_readM), 16'h0);
    reset_n = 1'b1;

    tick();
    chk("e1_val",    16'(ir_valid_id), 16'h0);
    chk("e1_rd",     16'(imem.i_readM), 16'h1);
    chk("e1_addr",   imem.i_address, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("seq_ir",  ir_id, 16'h1000 + 16'(i));
      chk("seq_pc",  pc_id, 16'(i));
      chk("seq_val", 16'(ir_valid_id), 16'h1);
    end

    tick();
    tick();
    lat = 3;
    chk("lat_a0",    imem.i_address, 16'h0005);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("lat_addr", imem.i_address, 16'h0005);
      chk("lat_ir",   ir_id, 16'hF01C);
      chk("lat_val",  16'(ir_valid_id), 16'h0);
    end
    tick();
    chk("lat_ir5",   ir_id, 16'h1005);
    chk("lat_pc5",   pc_id, 16'h0005);
    lat = 1;

    ir_write = 1'b0;
    pc_write = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("hold_rd", 16'(imem.i_readM), 16'h0);
      chk("hold_ir", ir_id, 16'h1005);
    end
    ir_write = 1'b1;
    pc_write = 1'b1;
    tick();
    chk("hold_ld",   ir_id, 16'h1006);
    chk("hold_pc",   pc_id, 16'h0006);
    chk("hold_nxt",  imem.i_address, 16'h0007);
    tick();
    chk("post_hold", ir_id, 16'h1007);

    lat            = 3;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0040;
    tick();
    redirect_valid = 1'b0;
    chk("kill_a1",   imem.i_address, 16'h0008);
    chk("kill_v1",   16'(ir_valid_id), 16'h0);
    tick();
    chk("kill_a2",   imem.i_address, 16'h0008);
    chk("kill_v2",   16'(ir_valid_id), 16'h0);
    tick();
    chk("kill_v3",   16'(ir_valid_id), 16'h0);
    chk("kill_a3",   imem.i_address, 16'h0040);
    lat = 1;
    tick();
    chk("redir_ir",  ir_id, 16'h1040);
    chk("redir_pc",  pc_id, 16'h0040);

    upd_valid  = 1'b1;
    upd_pc     = 16'h0008;
    upd_target = 16'h0020;
    upd_taken  = 1'b1;
    tick();
    tick();
    upd_valid      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0008;
    tick();
    redirect_valid = 1'b0;
    chk("btb_a8",    imem.i_address, 16'h0008);
    tick();
    chk("btb_ir",    ir_id, 16'h1008);
    chk("btb_pt",    16'(pred_taken_id), 16'h1);
    chk("btb_ptg",   pred_target_id, 16'h0020);
    chk("btb_nxt",   imem.i_address, 16'h0020);

    upd_valid = 1'b1;
    upd_taken = 1'b0;
    tick();
    tick();
    upd_valid      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0008;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("nt_ir",     ir_id, 16'h1008);
    chk("nt_pt",     16'(pred_taken_id), 16'h0);
    chk("nt_ptg",    pred_target_id, 16'h0009);
    chk("nt_nxt",    imem.i_address, 16'h0009);

    flush_if       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0010;
    tick();
    flush_if       = 1'b0;
    redirect_valid = 1'b0;
    chk("fl_ir",     ir_id, 16'hF01C);
    chk("fl_val",    16'(ir_valid_id), 16'h0);
    chk("fl_addr",   imem.i_address, 16'h0010);
    tick();
    chk("fl_nir",    ir_id, 16'h1010);
    chk("fl_npc",    pc_id, 16'h0010);

    ir_write = 1'b0;
    pc_write = 1'b0;
    tick();
    chk("ar_hold",   16'(imem.i_readM), 16'h0);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_ir",     ir_id, 16'hF01C);
    chk("ar_pc",     pc_id, 16'h0000);
    chk("ar_val",    16'(ir_valid_id), 16'h0);
    chk("ar_pt",     16'(pred_taken_id), 16'h0);
    chk("ar_ptg",    pred_target_id, 16'h0000);
    chk("ar_rd",     16'(imem.i_readM), 16'h0);
    chk("ar_addr",   imem.i_address, 16'h0000);

    tick();
    reset_n        = 1'b1;
    ir_write       = 1'b1;
    pc_write       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFF;
    tick();
    redirect_valid = 1'b0;
    chk("wr_addr",   imem.i_address, 16'hFFFF);
    tick();
    chk("wr_ir",     ir_id, 16'h0FFF);
    chk("wr_pc",     pc_id, 16'hFFFF);
    chk("wr_nxt",    imem.i_address, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
